// File: rtl/inst_stream_loader_if.sv
// Beat-source and instruction-consumer bundle of the instruction stream loader.
// The slave modport is the loader's side; the master modport is its environment.
interface inst_stream_loader_if #(
  parameter int INST_LEN = 220,
  parameter int BEAT_LEN = 512,
  parameter int DEPTH    = 32,
  parameter int CNT_LEN  = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                start;
  logic [CNT_LEN-1:0]  inst_total;
  logic                beat_valid;
  logic                beat_ready;
  logic [BEAT_LEN-1:0] beat_data;
  logic                inst_req;
  logic                inst_empty;
  logic [INST_LEN-1:0] instruct;
  logic [LVL_W-1:0]    level;
  logic                busy;
  logic                done;

  modport master (
    output start, inst_total, beat_valid, beat_data, inst_req,
    input  beat_ready, inst_empty, instruct, level, busy, done
  );

  modport slave (
    input  start, inst_total, beat_valid, beat_data, inst_req,
    output beat_ready, inst_empty, instruct, level, busy, done
  );
endinterface

// File: rtl/inst_stream_loader.sv
// Unpacks two-instruction DDR beats into an instruction FIFO for the accelerator control,
// loading one program of inst_total instructions per accepted start pulse.
module inst_stream_loader #(
  parameter int INST_LEN = 220,
  parameter int BEAT_LEN = 512,
  parameter int DEPTH    = 32,
  parameter int CNT_LEN  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_stream_loader_if.slave  bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int SLOT1 = BEAT_LEN / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_LEN-1:0]  remaining_q, remaining_d;
  logic [LW-1:0]       wptr_q, rptr_q, level_q, level_d;
  logic [LW-1:0]       wptr1, n_wr;
  logic                empty_q, empty_d;
  logic                done_q, done_d;
  logic [INST_LEN-1:0] instruct_q;
  logic [INST_LEN-1:0] mem [DEPTH];

  logic beat_ready, xfer, pop, wr0, wr1;

  // Padding bits of each beat slot carry nothing.
  logic unused_pad;
  assign unused_pad = ^{bus.beat_data[SLOT1-1:INST_LEN],
                        bus.beat_data[BEAT_LEN-1:SLOT1+INST_LEN]};

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    wr0         = 1'b0;
    wr1         = 1'b0;

    // Ready depends only on registered state/level, so a two-slot beat always fits.
    beat_ready = (state_q == S_LOAD) && (level_q <= LW'(DEPTH - 2));
    xfer       = bus.beat_valid && beat_ready;
    pop        = bus.inst_req && !empty_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.inst_total == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_LOAD;
            remaining_d = bus.inst_total;
          end
        end
      end
      S_LOAD: begin
        if (xfer) begin
          wr0 = 1'b1;
          if (remaining_q >= CNT_LEN'(2)) begin
            wr1         = 1'b1;
            remaining_d = remaining_q - CNT_LEN'(2);
          end else begin
            remaining_d = '0;
          end
          if (remaining_q <= CNT_LEN'(2)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (empty_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    n_wr    = LW'(wr0) + LW'(wr1);
    wptr1   = wptr_q + LW'(1);
    level_d = level_q + n_wr - LW'(pop);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      done_q      <= 1'b0;
      instruct_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wptr_q      <= wptr_q + n_wr;
      level_q     <= level_d;
      empty_q     <= empty_d;
      done_q      <= done_d;
      if (pop) begin
        rptr_q     <= rptr_q + LW'(1);
        instruct_q <= mem[rptr_q[AW-1:0]];
      end
    end
  end

  // Storage carries no reset; occupancy is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (wr0) mem[wptr_q[AW-1:0]] <= bus.beat_data[INST_LEN-1:0];
    if (wr1) mem[wptr1[AW-1:0]]  <= bus.beat_data[SLOT1+INST_LEN-1:SLOT1];
  end

  assign bus.beat_ready = beat_ready;
  assign bus.inst_empty = empty_q;
  assign bus.instruct   = instruct_q;
  assign bus.level      = level_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
endmodule

// File: tb/tb_inst_stream_loader.sv
// Directed bench for inst_stream_loader: instruction n carries a recognisable pattern and
// beat b packs instructions 2b (slot0) and 2b+1 (slot1) plus filler in the padding bits.
module tb_inst_stream_loader;
  localparam int IL = 220;
  localparam int BL = 512;
  localparam int DP = 32;
  localparam int CL = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_stream_loader_if #(.INST_LEN(IL), .BEAT_LEN(BL), .DEPTH(DP), .CNT_LEN(CL)) bus ();

  inst_stream_loader #(.INST_LEN(IL), .BEAT_LEN(BL), .DEPTH(DP), .CNT_LEN(CL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  function automatic logic [IL-1:0] pat(input int n);
    logic [15:0] h;
    h = n[15:0];
    return {12'hA5C, {13{h}}};
  endfunction

  function automatic logic [BL-1:0] mk_beat(input int b);
    return {36'hFEEDC0DE1, pat(2*b+1), 36'hBADF00D23, pat(2*b)};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_prog(input int total);
    bus.start      = 1'b1;
    bus.inst_total = total[CL-1:0];
    step();
    bus.start = 1'b0;
  endtask

  task automatic feed(input int b);
    bus.beat_valid = 1'b1;
    bus.beat_data  = mk_beat(b);
    for (int k = 0; k < 50 && bus.beat_ready !== 1'b1; k++) step();
    if (bus.beat_ready !== 1'b1) check("feed_timeout", 256'(bus.beat_ready), 256'(1));
    step();
    bus.beat_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input int n);
    bus.inst_req = 1'b1;
    step();
    bus.inst_req = 1'b0;
    check(tag, 256'(bus.instruct), 256'(pat(n)));
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && bus.busy !== 1'b0; k++) step();
    check("idle_reached", 256'(bus.busy), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, acc, popped, max_level;
    logic xfer, fire;

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.inst_total = '0;
    bus.beat_valid = 1'b0;
    bus.beat_data  = '0;
    bus.inst_req   = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();

    check("rst_level", 256'(bus.level), 256'(0));
    check("rst_empty", 256'(bus.inst_empty), 256'(1));
    check("rst_instruct", 256'(bus.instruct), 256'(0));
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_ready", 256'(bus.beat_ready), 256'(0));
    check("rst_done", 256'(bus.done), 256'(0));

    // 1: four instructions in two back-to-back beats
    start_prog(4);
    check("t1_busy", 256'(bus.busy), 256'(1));
    check("t1_ready", 256'(bus.beat_ready), 256'(1));
    bus.beat_valid = 1'b1;
    bus.beat_data  = mk_beat(0);
    step();
    check("t1_level2", 256'(bus.level), 256'(2));
    bus.beat_data = mk_beat(1);
    step();
    bus.beat_valid = 1'b0;
    check("t1_level4", 256'(bus.level), 256'(4));
    check("t1_drain_busy", 256'(bus.busy), 256'(1));
    check("t1_drain_ready", 256'(bus.beat_ready), 256'(0));

    // 2: pop all four in order
    d0 = done_cnt;
    pop_check("t2_pop0", 0);
    pop_check("t2_pop1", 1);
    pop_check("t2_pop2", 2);
    pop_check("t2_pop3", 3);
    check("t2_empty", 256'(bus.inst_empty), 256'(1));
    check("t2_level", 256'(bus.level), 256'(0));
    step();
    check("t2_done", 256'(bus.done), 256'(1));
    step(); step();
    check("t2_done_once", 256'(done_cnt - d0), 256'(1));
    check("t2_idle", 256'(bus.busy), 256'(0));

    // 3: odd total, upper slot of last beat discarded
    start_prog(3);
    feed(5);
    check("t3_level2", 256'(bus.level), 256'(2));
    feed(6);
    check("t3_level3", 256'(bus.level), 256'(3));
    check("t3_ready", 256'(bus.beat_ready), 256'(0));
    pop_check("t3_pop0", 10);
    pop_check("t3_pop1", 11);
    pop_check("t3_pop2", 12);
    check("t3_empty", 256'(bus.inst_empty), 256'(1));
    wait_idle();
    bus.inst_req = 1'b1;
    step();
    bus.inst_req = 1'b0;
    check("t3_hold_empty", 256'(bus.instruct), 256'(pat(12)));

    // 4: fill to DEPTH, then stream out 100 with wrap
    d0 = done_cnt;
    start_prog(100);
    acc = 0;
    for (int k = 0; k < 200 && bus.level != 32; k++) begin
      bus.beat_valid = 1'b1;
      bus.beat_data  = mk_beat(20 + acc);
      xfer = bus.beat_ready;
      step();
      if (xfer) acc++;
    end
    check("t4_full_level", 256'(bus.level), 256'(32));
    check("t4_full_ready", 256'(bus.beat_ready), 256'(0));
    check("t4_full_beats", 256'(acc), 256'(16));
    step(); step(); step();
    check("t4_full_hold", 256'(bus.level), 256'(32));
    popped = 0;
    max_level = 32;
    bus.inst_req = 1'b1;
    for (int k = 0; k < 1000 && popped < 100; k++) begin
      bus.beat_valid = (acc < 50);
      bus.beat_data  = mk_beat(20 + acc);
      xfer = bus.beat_valid && bus.beat_ready;
      fire = !bus.inst_empty;
      step();
      if (xfer) acc++;
      if (int'(bus.level) > max_level) max_level = int'(bus.level);
      if (fire) begin
        check($sformatf("t4_pop%0d", popped), 256'(bus.instruct), 256'(pat(40 + popped)));
        popped++;
      end
    end
    bus.inst_req   = 1'b0;
    bus.beat_valid = 1'b0;
    check("t4_popped", 256'(popped), 256'(100));
    check("t4_max_level", 256'(max_level), 256'(32));
    wait_idle();
    step();
    check("t4_done_once", 256'(done_cnt - d0), 256'(1));

    // 5: zero-length program, and start ignored while loading
    d0 = done_cnt;
    start_prog(0);
    check("t5_zero_busy", 256'(bus.busy), 256'(0));
    check("t5_zero_done", 256'(bus.done), 256'(1));
    step();
    check("t5_zero_done_clr", 256'(bus.done), 256'(0));
    start_prog(2);
    check("t5_load_busy", 256'(bus.busy), 256'(1));
    start_prog(8);
    check("t5_restart_busy", 256'(bus.busy), 256'(1));
    check("t5_restart_ready", 256'(bus.beat_ready), 256'(1));
    feed(80);
    check("t5_remaining_kept", 256'(bus.beat_ready), 256'(0));
    check("t5_level", 256'(bus.level), 256'(2));
    pop_check("t5_pop0", 160);
    pop_check("t5_pop1", 161);
    wait_idle();
    step();
    check("t5_done_count", 256'(done_cnt - d0), 256'(2));

    // 6: reset mid-load, then a clean reload
    start_prog(20);
    for (int b = 90; b < 96; b++) feed(b);
    check("t6_level12", 256'(bus.level), 256'(12));
    pop_check("t6_pop0", 180);
    pop_check("t6_pop1", 181);
    check("t6_level10", 256'(bus.level), 256'(10));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_empty", 256'(bus.inst_empty), 256'(1));
    check("t6_rst_level", 256'(bus.level), 256'(0));
    check("t6_rst_instruct", 256'(bus.instruct), 256'(0));
    check("t6_rst_busy", 256'(bus.busy), 256'(0));
    check("t6_rst_ready", 256'(bus.beat_ready), 256'(0));
    step();
    rst_n = 1'b1;
    step();
    start_prog(2);
    feed(100);
    check("t6_reload_level", 256'(bus.level), 256'(2));
    pop_check("t6_reload0", 200);
    pop_check("t6_reload1", 201);
    check("t6_reload_empty", 256'(bus.inst_empty), 256'(1));
    bus.inst_req = 1'b1;
    step();
    bus.inst_req = 1'b0;
    check("t6_hold_empty", 256'(bus.instruct), 256'(pat(201)));
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
